// File: rtl/fp_normalize_round.sv
// Normalize/round stage behind the FP adder: one normalization shift per cycle,
// round-to-nearest-even, overflow/underflow detection and packing of the result.
module fp_normalize_round #(
    parameter int EXP_W  = 6,
    parameter int FRAC_W = 25,
    parameter int BIAS   = 31
) (
    input  logic                      clock_100kHz,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [FRAC_W+1:0]         in_mant,
    input  logic                      in_guard,
    input  logic                      in_sticky,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     data_out,
    output logic [3:0]                status_out
);

    localparam int MW = FRAC_W + 2;
    localparam int EW = EXP_W + 1;
    localparam int DW = 1 + EXP_W + FRAC_W;

    // All-ones exponent is reserved for overflow; equals 2*BIAS+1 for this encoding.
    localparam logic [EW-1:0] EXP_MAX = EW'(2 * BIAS + 1);
    localparam logic [EW-1:0] EXP_PRE = EXP_MAX - EW'(1);
    localparam logic [EW-1:0] EXP_ONE = EW'(1);

    localparam logic [3:0] ST_EXACT = 4'b0001;
    localparam logic [3:0] ST_INEX  = 4'b1000;
    localparam logic [3:0] ST_OVF   = 4'b1010;
    localparam logic [3:0] ST_UNF   = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_ROUND,
        S_OUT
    } state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic [MW-1:0]   mant_q, mant_d;
    logic            guard_q, guard_d;
    logic            sticky_q, sticky_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [3:0]      status_q, status_d;

    logic [EW-1:0]   exp_inc;
    logic [EW-1:0]   exp_dec;
    logic            rnd_inc;
    logic [MW-1:0]   rnd_sum;
    logic            is_zero;
    logic [DW-1:0]   ovf_word;
    logic [DW-1:0]   zero_word;

    function automatic logic [DW-1:0] pack(
        input logic              s,
        input logic [EXP_W-1:0]  e,
        input logic [FRAC_W-1:0] f
    );
        return {s, e, f};
    endfunction

    assign exp_inc   = exp_q + EW'(1);
    assign exp_dec   = exp_q - EW'(1);
    assign is_zero   = (mant_q == '0) && !guard_q && !sticky_q;
    assign rnd_inc   = guard_q & (sticky_q | mant_q[0]);
    assign rnd_sum   = {1'b0, mant_q[MW-2:0]} + MW'(rnd_inc);
    assign ovf_word  = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    assign zero_word = {sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        status_d = status_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = {1'b0, in_exp};
                    mant_d   = in_mant;
                    guard_d  = in_guard;
                    sticky_d = in_sticky;
                    state_d  = S_NORM;
                end
            end

            S_NORM: begin
                if (is_zero) begin
                    data_d   = zero_word;
                    status_d = ST_EXACT;
                    state_d  = S_OUT;
                end else if (exp_q == EXP_MAX) begin
                    data_d   = ovf_word;
                    status_d = ST_OVF;
                    state_d  = S_OUT;
                end else if (exp_q == '0) begin
                    data_d   = zero_word;
                    status_d = ST_UNF;
                    state_d  = S_OUT;
                end else if (mant_q[MW-1]) begin
                    if (exp_q == EXP_PRE) begin
                        data_d   = ovf_word;
                        status_d = ST_OVF;
                        state_d  = S_OUT;
                    end else begin
                        mant_d   = {1'b0, mant_q[MW-1:1]};
                        guard_d  = mant_q[0];
                        sticky_d = guard_q | sticky_q;
                        exp_d    = exp_inc;
                    end
                end else if (!mant_q[MW-2]) begin
                    if (exp_q == EXP_ONE) begin
                        data_d   = zero_word;
                        status_d = ST_UNF;
                        state_d  = S_OUT;
                    end else begin
                        mant_d  = {mant_q[MW-2:0], guard_q};
                        guard_d = 1'b0;
                        exp_d   = exp_dec;
                    end
                end else begin
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                state_d  = S_OUT;
                status_d = (guard_q | sticky_q) ? ST_INEX : ST_EXACT;
                // Carry out of the hidden bit: mantissa rolls over to exactly 1.0.
                if (rnd_sum[MW-1]) begin
                    mant_d = {2'b01, {FRAC_W{1'b0}}};
                    exp_d  = exp_inc;
                    if (exp_inc == EXP_MAX) begin
                        data_d   = ovf_word;
                        status_d = ST_OVF;
                    end else begin
                        data_d = pack(sign_q, exp_inc[EXP_W-1:0],
                                      {FRAC_W{1'b0}});
                    end
                end else begin
                    mant_d = rnd_sum;
                    data_d = pack(sign_q, exp_q[EXP_W-1:0],
                                  rnd_sum[FRAC_W-1:0]);
                end
            end

            S_OUT: begin
                valid_d = 1'b1;
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = valid_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Vector table plus scoreboard bench for fp_normalize_round, with
// backpressure and mid-operation reset sequences.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [5:0]  in_exp = '0;
    logic [26:0] in_mant = '0;
    logic        in_guard = 1'b0;
    logic        in_sticky = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        string       nm;
        logic        sign;
        logic [5:0]  exp;
        logic [26:0] mant;
        logic        g;
        logic        s;
        logic [31:0] data;
        logic [3:0]  st;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    vec_t vecs [15];
    exp_t sb [$];

    fp_normalize_round dut (
        .clock_100kHz(clk),
        .reset(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_sign(in_sign),
        .in_exp(in_exp),
        .in_mant(in_mant),
        .in_guard(in_guard),
        .in_sticky(in_sticky),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .status_out(status_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic accept(input vec_t v);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk({v.nm, "_ready"}, 32'(in_ready), 32'd1);
        in_sign   = v.sign;
        in_exp    = v.exp;
        in_mant   = v.mant;
        in_guard  = v.g;
        in_sticky = v.s;
        in_valid  = 1'b1;
        sb.push_back('{v.data, v.st});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input string nm, input int lat);
        int n = 0;
        exp_t e;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_lat"}, 32'(n), 32'(lat));
        if (out_valid) begin
            chk({nm, "_sb"}, 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({nm, "_data"}, data_out, e.d);
                chk({nm, "_status"}, 32'(status_out), 32'(e.s));
            end
            if (out_ready) begin
                @(posedge clk);
                #1;
                chk({nm, "_done_valid"}, 32'(out_valid), 32'd0);
                chk({nm, "_done_ready"}, 32'(in_ready), 32'd1);
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"two_carry",  1'b0, 6'd31, 27'h4000000, 1'b0, 1'b0,
                     32'h40000000, 4'b0001, 4};
        vecs[1]  = '{"one_norm",   1'b0, 6'd31, 27'h2000000, 1'b0, 1'b0,
                     32'h3E000000, 4'b0001, 3};
        vecs[2]  = '{"half_left",  1'b0, 6'd31, 27'h1000000, 1'b0, 1'b0,
                     32'h3C000000, 4'b0001, 4};
        vecs[3]  = '{"rnd_carry",  1'b0, 6'd31, 27'h3FFFFFF, 1'b1, 1'b1,
                     32'h40000000, 4'b1000, 3};
        vecs[4]  = '{"tie_even",   1'b0, 6'd31, 27'h2000002, 1'b1, 1'b0,
                     32'h3E000002, 4'b1000, 3};
        vecs[5]  = '{"tie_odd",    1'b0, 6'd31, 27'h2000001, 1'b1, 1'b0,
                     32'h3E000002, 4'b1000, 3};
        vecs[6]  = '{"ovf_carry",  1'b1, 6'd62, 27'h4000000, 1'b0, 1'b0,
                     32'hFE000000, 4'b1010, 2};
        vecs[7]  = '{"unf_exp1",   1'b0, 6'd1,  27'h0000001, 1'b0, 1'b0,
                     32'h00000000, 4'b1100, 2};
        vecs[8]  = '{"zero_neg",   1'b1, 6'd17, 27'h0000000, 1'b0, 1'b0,
                     32'h80000000, 4'b0001, 2};
        vecs[9]  = '{"exp63_in",   1'b0, 6'd63, 27'h2000000, 1'b0, 1'b0,
                     32'h7E000000, 4'b1010, 2};
        vecs[10] = '{"exp0_in",    1'b1, 6'd0,  27'h2000000, 1'b0, 1'b0,
                     32'h80000000, 4'b1100, 2};
        vecs[11] = '{"worst_26",   1'b0, 6'd40, 27'h0000000, 1'b1, 1'b0,
                     32'h1C000000, 4'b0001, 29};
        vecs[12] = '{"rnd_ovf",    1'b0, 6'd62, 27'h3FFFFFF, 1'b1, 1'b0,
                     32'h7E000000, 4'b1010, 3};
        vecs[13] = '{"carry_lsb",  1'b0, 6'd31, 27'h6000001, 1'b0, 1'b0,
                     32'h41000000, 4'b1000, 4};
        vecs[14] = '{"left_stky",  1'b0, 6'd31, 27'h1000000, 1'b1, 1'b1,
                     32'h3C000001, 4'b1000, 4};

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_status", 32'(status_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            accept(vecs[i]);
            collect(vecs[i].nm, vecs[i].lat);
        end

        // Backpressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        accept(vecs[1]);
        collect("bp", 3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", data_out, 32'h3E000000);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_keep_data", data_out, 32'h3E000000);

        // Reset in the middle of a long left-normalization.
        accept(vecs[11]);
        repeat (4) @(posedge clk);
        #2;
        chk("abort_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_data", data_out, 32'd0);
        chk("abort_status", 32'(status_out), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("abort_no_output", 32'(seen), 32'd0);
        end

        accept(vecs[13]);
        collect("after_rst", 4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
